// File: rtl/vstage_fork_buff.sv
// rtl/vstage_fork_buff.sv - Elastic DEPTH-entry buffer forking each entry to NUM_OUT consumers
module vstage_fork_buff #(
  parameter int DW      = 32,
  parameter int DEPTH   = 2,
  parameter int NUM_OUT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DW-1:0]              data_o,
  output logic [NUM_OUT-1:0]         valid_o,
  input  logic [NUM_OUT-1:0]         ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       idle_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wp_q, wp_d;
  logic [AW-1:0]      rp_q, rp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_OUT-1:0] taken_q, taken_d;

  logic               full, empty;
  logic               push, retire;
  logic [NUM_OUT-1:0] fire, done;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Outputs come from registered state only, so ready_i never reaches ready_o
  // and valid_i never reaches valid_o combinationally.
  assign ready_o = ~full;
  assign valid_o = {NUM_OUT{~empty}} & ~taken_q;
  assign data_o  = mem_q[rp_q];
  assign idle_o  = empty;
  assign count_o = cnt_q;

  assign push   = valid_i & ready_o;
  assign fire   = valid_o & ready_i;
  assign done   = taken_q | fire;
  assign retire = ~empty & (&done);

  // Next-state: flush wins over everything; otherwise push/retire move the pointers.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
      taken_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + AW'(1);
      end
      if (retire) begin
        rp_d    = rp_q + AW'(1);
        taken_d = '0;
      end else begin
        taken_d = taken_q | fire;
      end
      if (push && !retire) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!push && retire) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Control state register; storage contents are deliberately left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      taken_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // Payload storage write; a push in a flush cycle is discarded.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_q[wp_q] <= data_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_retire_empty: assert property (@(posedge clk) disable iff (rst) !(retire && empty));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_vstage_fork_buff.sv
// tb/tb_vstage_fork_buff.sv - Directed and randomized checks of vstage_fork_buff against a queue model
module tb_vstage_fork_buff;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int NUM_OUT = 2;
  localparam int CW      = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_i;
  logic [DW-1:0]      data_i;
  logic               valid_i;
  logic               ready_o;
  logic [DW-1:0]      data_o;
  logic [NUM_OUT-1:0] valid_o;
  logic [NUM_OUT-1:0] ready_i;
  logic [CW-1:0]      count_o;
  logic               idle_o;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending payloads plus the set of consumers
  // that have already taken the head entry.
  logic [DW-1:0]      mq[$];
  logic [NUM_OUT-1:0] mtaken;

  vstage_fork_buff #(.DW(DW), .DEPTH(DEPTH), .NUM_OUT(NUM_OUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .idle_o  (idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NUM_OUT-1:0] ev;
    ev = (mq.size() != 0) ? ~mtaken : '0;
    chk("m_ready", 64'(ready_o), 64'(mq.size() < DEPTH));
    chk("m_valid", 64'(valid_o), 64'(ev));
    chk("m_count", 64'(count_o), 64'(mq.size()));
    chk("m_idle",  64'(idle_o),  64'(mq.size() == 0));
    if (mq.size() != 0) chk("m_data", 64'(data_o), 64'(mq[0]));
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model, land at posedge+1.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [NUM_OUT-1:0] r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(negedge clk);
    check_model();
    if (f) begin
      mq.delete();
      mtaken = '0;
    end else begin
      logic [NUM_OUT-1:0] fire;
      bit was_full;
      was_full = (mq.size() == DEPTH);
      fire = (mq.size() != 0) ? (r & ~mtaken) : '0;
      if (mq.size() != 0 && (&(mtaken | fire))) begin
        void'(mq.pop_front());
        mtaken = '0;
      end else begin
        mtaken = mtaken | fire;
      end
      if (v && !was_full) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = '0;
    mtaken  = '0;
    #12;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_idle",  64'(idle_o),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic fork
    step(1'b1, 32'hA5, 2'b11, 1'b0);
    chk("fork_valid", 64'(valid_o), 64'd3);
    chk("fork_data",  64'(data_o),  64'hA5);
    chk("fork_cnt1",  64'(count_o), 64'd1);
    step(1'b0, 32'h0, 2'b11, 1'b0);
    chk("fork_cnt0",  64'(count_o), 64'd0);
    chk("fork_idle",  64'(idle_o),  64'd1);

    // Skewed accept
    step(1'b1, 32'h11, 2'b00, 1'b0);
    step(1'b1, 32'h22, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 2'b01, 1'b0);
      chk("skew_valid", 64'(valid_o), 64'd2);
      chk("skew_data",  64'(data_o),  64'h11);
    end
    step(1'b0, 32'h0, 2'b10, 1'b0);
    chk("skew_next_valid", 64'(valid_o), 64'd3);
    chk("skew_next_data",  64'(data_o),  64'h22);
    step(1'b0, 32'h0, 2'b11, 1'b0);
    chk("skew_idle", 64'(idle_o), 64'd1);

    // Full boundary
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h100 + i), 2'b00, 1'b0);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_count", 64'(count_o), 64'd4);
    step(1'b1, 32'hBAD, 2'b11, 1'b0);
    chk("full_after_ready", 64'(ready_o), 64'd1);
    chk("full_after_count", 64'(count_o), 64'd3);
    chk("full_after_data",  64'(data_o),  64'h101);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2'b11, 1'b0);
    chk("full_drained", 64'(idle_o), 64'd1);

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(i), 2'b11, 1'b0);
      chk("wrap_data",  64'(data_o),  64'(i));
      chk("wrap_valid", 64'(valid_o), 64'd3);
      chk("wrap_cnt_le2", 64'(count_o <= 2), 64'd1);
    end
    step(1'b0, 32'h0, 2'b11, 1'b0);
    chk("wrap_idle", 64'(idle_o), 64'd1);

    // Flush mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h30 + i), 2'b00, 1'b0);
    step(1'b0, 32'h0, 2'b01, 1'b0);
    chk("flush_pre_valid", 64'(valid_o), 64'd2);
    step(1'b1, 32'h99, 2'b11, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_idle",  64'(idle_o),  64'd1);
    step(1'b1, 32'h77, 2'b00, 1'b0);
    chk("flush_push_valid", 64'(valid_o), 64'd3);
    chk("flush_push_data",  64'(data_o),  64'h77);
    step(1'b0, 32'h0, 2'b11, 1'b0);

    // Asynchronous reset between edges
    step(1'b1, 32'h41, 2'b00, 1'b0);
    step(1'b1, 32'h42, 2'b00, 1'b0);
    chk("arst_pre_count", 64'(count_o), 64'd2);
    valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    mq.delete();
    mtaken = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h5A, 2'b00, 1'b0);
    chk("arst_push_valid", 64'(valid_o), 64'd3);
    chk("arst_push_data",  64'(data_o),  64'h5A);
    step(1'b0, 32'h0, 2'b11, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), DW'($urandom), NUM_OUT'($urandom), ($urandom % 25) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vstage_fork_buff.md
# vstage_fork_buff

Parametrised elastic pipeline buffer for vector-unit stage boundaries (vRR→vIS, vRR→vMU, vIS→vEX). It generalises the single-consumer stage register to a DEPTH-entry FIFO that forks each entry to NUM_OUT independent consumers. Each consumer has its own valid/ready pair. An entry retires only after every consumer has accepted it. The block adds synchronous flush, occupancy count and idle reporting so that split data/info paths can share one buffer without ignoring any ready.

## Interface
- DW, 32, payload width in bits
- DEPTH, 2, number of entries; power of two, ≥2
- NUM_OUT, 2, number of fork consumers, 1..4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- flush_i  in  1  synchronous flush; discards all entries
- data_i  in  DW  producer payload
- valid_i  in  1  producer valid
- ready_o  out  1  buffer can accept (not full)
- data_o  out  DW  head-entry payload, shared by all consumers
- valid_o  out  NUM_OUT  per-consumer valid
- ready_i  in  NUM_OUT  per-consumer ready
- count_o  out  $clog2(DEPTH+1)  occupied entries
- idle_o  out  1  buffer empty

## Operation
- Storage: DEPTH×DW array plus write pointer wp and read pointer rp, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH. Occupancy cnt ranges 0..DEPTH.
- Per-consumer state: taken[NUM_OUT] records which consumers have already accepted the head entry.
- Output equations:
  - ready_o = (cnt != DEPTH). It depends only on state, never on ready_i or valid_i.
  - valid_o[k] = (cnt != 0) & ~taken[k].
  - data_o = mem[rp].
  - idle_o = (cnt == 0).
  - count_o = cnt.
- Handshakes:
  - push = valid_i & ready_o.
  - fire[k] = valid_o[k] & ready_i[k].
  - done[k] = taken[k] | fire[k].
  - retire = (cnt != 0) & (&done).
- Update rules (flush_i = 0):
  - On push: write mem[wp], then wp += 1.
  - On retire: rp += 1 and taken ← 0. Otherwise taken ← taken | fire.
  - cnt += push − retire.
- Simultaneous push and retire leaves cnt unchanged. This is legal at any cnt below DEPTH.
- At cnt == DEPTH, push is refused even if a retire happens in the same cycle.
- Consumers may accept in any cycles and in any order. A consumer that has accepted sees valid_o[k] = 0 until the head entry retires.
- Flush (flush_i = 1) has the highest priority. Next cycle: wp = rp = 0, cnt = 0, taken = 0. A push or fire in the flush cycle is discarded; there is no retire side-effect.
- Reset (rst asserted, at any time including mid-transfer): wp = rp = 0, cnt = 0, taken = 0. Memory contents are not reset.
- Reset values of outputs: ready_o = 1, valid_o = 0, count_o = 0, idle_o = 1, data_o = don't-care.
- NUM_OUT = 1 degenerates to a plain DEPTH-entry elastic FIFO with identical timing.

## Timing
- Latency: an entry pushed in cycle t is visible on valid_o/data_o in cycle t+1. There is no fall-through.
- Throughput: one entry per cycle when all consumers hold ready_i = 1 and DEPTH ≥ 2.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o.
- Stability: while valid_o[k] = 1 and fire[k] = 0, data_o stays stable and valid_o[k] stays asserted. The only exception is a flush.
- After retire in cycle t, the next entry (if cnt > 1) is presented in cycle t+1 with all valid_o bits set.
- count_o and idle_o reflect the registered state. They update the cycle after the causing push, retire or flush.
- Assertions:
  - no push while cnt == DEPTH;
  - no retire while cnt == 0;
  - cnt ≤ DEPTH at all times.

## Test plan
- Basic fork (NUM_OUT = 2, DEPTH = 2): push 0xA5 with both ready_i = 1. Expect valid_o = 2'b11 with data_o = 0xA5 in the next cycle, a retire the cycle after, and count_o returning 1→0.
- Skewed accept: push 0x11 and 0x22. Hold ready_i = 2'b01 for 3 cycles, then 2'b10. Expect:
  - valid_o = 2'b10 after consumer 0 fires;
  - data_o held at 0x11;
  - 0x22 presented with valid_o = 2'b11 the cycle after consumer 1 fires.
- Full boundary (DEPTH = 4): push 4 entries with ready_i = 0. Expect ready_o = 0 and count_o = 4. Raise both ready_i while valid_i = 1: the push is refused in the retire cycle, ready_o = 1 next cycle, and count_o = 3.
- Wrap-around: stream 10 entries 0..9 through DEPTH = 4 with ready_i = all-ones. Expect in-order delivery 0..9 on every consumer, count_o never above 2, and idle_o = 1 at the end.
- Flush mid-operation: with 3 entries held and taken = 2'b01, assert flush_i together with valid_i. Expect next cycle count_o = 0, valid_o = 0, idle_o = 1. A subsequent push of 0x77 appears with valid_o = all-ones.
- Async reset: assert rst between clock edges while cnt = 2. Expect valid_o = 0, count_o = 0 and ready_o = 1 immediately. After release, a push of 0x5A appears one cycle later.
